// File: rtl/dirtylena_if.sv
// Row bus between frame source and the dirtylena median filter: load strobe,
// incoming row and filtered row.
interface dirtylena_if #(
  parameter int ROW_W = 6144
);
  logic             SET;
  logic [ROW_W-1:0] row_in;
  logic [ROW_W-1:0] row_out;

  modport master (output SET, output row_in, input row_out);
  modport slave  (input SET, input row_in, output row_out);
endinterface

// File: rtl/dirtylena.sv
// Row-streaming 3x3 per-channel median filter for packed RGB rows (pixel 0 at MSBs).
// Define BORDER_REPLICATE_EN to median-filter the edge columns using edge replication.
module dirtylena #(
  parameter int COLS = 256,
  parameter int CH_W = 8,
  parameter int NCH  = 3
) (
  input  logic        CLK,
  input  logic        RST,
  dirtylena_if.slave  bus
);
  localparam int PIX_W = CH_W * NCH;
  localparam int ROW_W = COLS * PIX_W;
  localparam int IDX_W = $clog2(ROW_W);
  localparam int WIN_W = 9 * CH_W;

  // 19-exchange median-of-9 network; the median ends up in slot 4
  localparam int SORT_A [19] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int SORT_B [19] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } cnt_t;

  cnt_t             cnt;
  cnt_t             cnt_next;
  logic [ROW_W-1:0] row_a;
  logic [ROW_W-1:0] row_b;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] top_row;
  logic [ROW_W-1:0] med_row;

  function automatic logic [IDX_W-1:0] chan_base(input int p, input int c);
    return IDX_W'((COLS - 1 - p) * PIX_W + (NCH - 1 - c) * CH_W);
  endfunction

  function automatic logic [CH_W-1:0] median9(input logic [WIN_W-1:0] win);
    logic [CH_W-1:0] v [9];
    logic [CH_W-1:0] t;
    for (int i = 0; i < 9; i++) v[i] = win[i*CH_W +: CH_W];
    for (int k = 0; k < 19; k++) begin
      if (v[SORT_A[k]] > v[SORT_B[k]]) begin
        t            = v[SORT_A[k]];
        v[SORT_A[k]] = v[SORT_B[k]];
        v[SORT_B[k]] = t;
      end
    end
    return v[4];
  endfunction

  // Gathers the 3x3 neighbourhood of one channel; off-edge columns clamp to the edge
  function automatic logic [WIN_W-1:0] window(input logic [ROW_W-1:0] top,
                                              input logic [ROW_W-1:0] mid,
                                              input logic [ROW_W-1:0] bot,
                                              input int p, input int c);
    logic [WIN_W-1:0] win;
    logic [ROW_W-1:0] src;
    int               col;
    win = '0;
    for (int r = 0; r < 3; r++) begin
      src = (r == 0) ? top : ((r == 1) ? mid : bot);
      for (int d = 0; d < 3; d++) begin
        col = p + d - 1;
        if (col < 0) col = 0;
        if (col > COLS - 1) col = COLS - 1;
        win[(r*3+d)*CH_W +: CH_W] = src[chan_base(col, c) +: CH_W];
      end
    end
    return win;
  endfunction

  // The first image row uses itself as its top neighbour
  assign top_row = (cnt == CNT_ONE) ? row_b : row_a;

  always_comb begin
    med_row = '0;
    for (int p = 0; p < COLS; p++) begin
      for (int c = 0; c < NCH; c++) begin
`ifdef BORDER_REPLICATE_EN
        med_row[chan_base(p, c) +: CH_W] = median9(window(top_row, row_b, bus.row_in, p, c));
`else
        if (p == 0 || p == COLS - 1)
          med_row[chan_base(p, c) +: CH_W] = row_b[chan_base(p, c) +: CH_W];
        else
          med_row[chan_base(p, c) +: CH_W] = median9(window(top_row, row_b, bus.row_in, p, c));
`endif
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) cnt <= CNT_EMPTY;
    else      cnt <= cnt_next;
  end

  always_comb begin
    cnt_next = cnt;
    if (bus.SET) begin
      case (cnt)
        CNT_EMPTY: cnt_next = CNT_ONE;
        default:   cnt_next = CNT_FULL;
      endcase
    end
  end

  // No output until a row has a bottom neighbour available
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      row_a <= '0;
      row_b <= '0;
      row_q <= '0;
    end else if (bus.SET) begin
      row_b <= bus.row_in;
      if (cnt != CNT_EMPTY) begin
        row_a <= row_b;
        row_q <= med_row;
      end
    end
  end

  assign bus.row_out = row_q;
endmodule

// File: tb/tb_dirtylena.sv
// Scoreboard bench for dirtylena: a counting-median row model predicts every output row.
module tb_dirtylena;
  localparam int COLS  = 256;
  localparam int CH_W  = 8;
  localparam int NCH   = 3;
  localparam int PIX_W = 24;
  localparam int ROW_W = COLS * PIX_W;
`ifdef BORDER_REPLICATE_EN
  localparam logic [23:0] BORDER_EXP = 24'hAAAAAA;
`else
  localparam logic [23:0] BORDER_EXP = 24'h000000;
`endif

  typedef logic [ROW_W-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dirtylena_if #(.ROW_W(ROW_W)) bus ();
  dirtylena #(.COLS(COLS), .CH_W(CH_W), .NCH(NCH)) dut (.CLK(clk), .RST(rst), .bus(bus));

  row_t exp_q[$];
  row_t m_a, m_b, m_out;
  int   m_cnt;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [23:0] get_pix(row_t r, int p);
    return r[ROW_W-1-PIX_W*p -: PIX_W];
  endfunction

  function automatic row_t put_pix(row_t r, int p, logic [23:0] v);
    r[ROW_W-1-PIX_W*p -: PIX_W] = v;
    return r;
  endfunction

  function automatic row_t fill_row(logic [23:0] v);
    row_t r;
    for (int p = 0; p < COLS; p++) r[ROW_W-1-PIX_W*p -: PIX_W] = v;
    return r;
  endfunction

  // narrow=1 keeps channel values in 0..3 so medians hit plenty of ties
  function automatic row_t rand_row(int narrow);
    row_t r;
    for (int b = 0; b < ROW_W / 8; b++)
      r[b*8 +: 8] = narrow ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic logic [7:0] med_count(logic [71:0] vals);
    int lt, le;
    for (int i = 0; i < 9; i++) begin
      lt = 0;
      le = 0;
      for (int j = 0; j < 9; j++) begin
        if (vals[j*8 +: 8] <  vals[i*8 +: 8]) lt++;
        if (vals[j*8 +: 8] <= vals[i*8 +: 8]) le++;
      end
      if (lt <= 4 && le >= 5) return vals[i*8 +: 8];
    end
    return 8'h00;
  endfunction

  function automatic row_t model_med(row_t top, row_t mid, row_t bot);
    row_t        o;
    logic [71:0] vals;
    logic [23:0] px;
    int          q, n;
    o = '0;
    for (int p = 0; p < COLS; p++) begin
`ifndef BORDER_REPLICATE_EN
      if (p == 0 || p == COLS - 1) begin
        o = put_pix(o, p, get_pix(mid, p));
        continue;
      end
`endif
      px = '0;
      for (int ch = 0; ch < 3; ch++) begin
        n = 0;
        for (int dc = -1; dc <= 1; dc++) begin
          q = p + dc;
          if (q < 0) q = 0;
          if (q > COLS - 1) q = COLS - 1;
          vals[n*8 +: 8] = get_pix(top, q) >> (16 - 8*ch); n++;
          vals[n*8 +: 8] = get_pix(mid, q) >> (16 - 8*ch); n++;
          vals[n*8 +: 8] = get_pix(bot, q) >> (16 - 8*ch); n++;
        end
        px[16-8*ch +: 8] = med_count(vals);
      end
      o = put_pix(o, p, px);
    end
    return o;
  endfunction

  task automatic checkRow(string tag, row_t obs, row_t expv);
    int pix;
    pix = 0;
    for (int p = COLS - 1; p >= 0; p--)
      if (get_pix(obs, p) !== get_pix(expv, p)) pix = p;
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s pixel=%0d observed=%h expected=%h", tag, pix,
             get_pix(obs, pix), get_pix(expv, pix));
    end
  endtask

  task automatic checkPix(string tag, int p, logic [23:0] expv);
    total++;
    assert (get_pix(bus.row_out, p) === expv) else begin
      bad++;
      $error("[TB] FAIL %s pixel=%0d observed=%h expected=%h", tag, p,
             get_pix(bus.row_out, p), expv);
    end
  endtask

  // Drives one edge and advances the reference model, queueing any produced row
  task automatic applyStimulus(row_t r, logic s);
    @(negedge clk);
    bus.row_in = r;
    bus.SET    = s;
    if (s && rst) begin
      case (m_cnt)
        0: begin
          m_b   = r;
          m_cnt = 1;
        end
        1: begin
          exp_q.push_back(model_med(m_b, m_b, r));
          m_a   = m_b;
          m_b   = r;
          m_cnt = 2;
        end
        default: begin
          exp_q.push_back(model_med(m_a, m_b, r));
          m_a = m_b;
          m_b = r;
        end
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string tag);
    if (exp_q.size() > 0) m_out = exp_q.pop_front();
    checkRow(tag, bus.row_out, m_out);
  endtask

  task automatic modelClear();
    exp_q.delete();
    m_a   = '0;
    m_b   = '0;
    m_out = '0;
    m_cnt = 0;
  endtask

  task automatic doReset(string tag);
    @(negedge clk);
    bus.SET = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    modelClear();
    checkRow(tag, bus.row_out, m_out);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    row_t u, base, r1, g, m, a, r0, rr1, r2;
    bus.SET    = 1'b0;
    bus.row_in = '0;
    modelClear();
    #1 rst = 1'b0;
    #1 checkRow("reset_init", bus.row_out, '0);

    $display("[TB] reset hold with SET toggling");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(rand_row(0), 1'((i + 1) % 2));
      checkOutput("reset_hold");
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(rand_row(0), 1'b0);
      checkOutput("idle_after_reset");
    end

    $display("[TB] uniform image");
    u = fill_row(24'h808080);
    applyStimulus(u, 1'b1); checkOutput("uniform_first_load");
    applyStimulus(u, 1'b1); checkOutput("uniform_row0");
    checkRow("uniform_row0_const", bus.row_out, u);
    applyStimulus(u, 1'b1); checkOutput("uniform_row1");
    checkRow("uniform_row1_const", bus.row_out, u);

    $display("[TB] salt noise");
    doReset("salt_reset");
    base = fill_row(24'h101010);
    r1   = put_pix(base, 100, 24'hFFFFFF);
    applyStimulus(base, 1'b1); checkOutput("salt_load0");
    applyStimulus(r1, 1'b1);   checkOutput("salt_row0");
    applyStimulus(base, 1'b1); checkOutput("salt_row1");
    checkPix("salt_row1_p100", 100, 24'h101010);
    checkRow("salt_row1_const", bus.row_out, base);
    applyStimulus(base, 1'b1); checkOutput("salt_row2");

    $display("[TB] channel independence");
    doReset("chan_reset");
    g = fill_row(24'h00FF00);
    m = put_pix(g, 50, 24'hFF0000);
    applyStimulus(g, 1'b1); checkOutput("chan_load0");
    applyStimulus(m, 1'b1); checkOutput("chan_row0");
    applyStimulus(g, 1'b1); checkOutput("chan_row1");
    checkPix("chan_p50", 50, 24'h00FF00);

    $display("[TB] border column");
    doReset("border_reset");
    a = fill_row(24'hAAAAAA);
    m = put_pix(a, 0, 24'h000000);
    applyStimulus(a, 1'b1); checkOutput("border_load0");
    applyStimulus(m, 1'b1); checkOutput("border_row0");
    applyStimulus(a, 1'b1); checkOutput("border_row1");
    checkPix("border_p0", 0, BORDER_EXP);
    checkPix("border_p1", 1, 24'hAAAAAA);

    $display("[TB] SET gating, latency and flush");
    doReset("gate_reset");
    r0  = rand_row(0);
    rr1 = rand_row(1);
    r2  = rand_row(1);
    applyStimulus(r0, 1'b1);  checkOutput("gate_load_r0");
    applyStimulus(rr1, 1'b1); checkOutput("gate_filt_r0");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rand_row(0), 1'b0);
      checkOutput("gate_hold");
    end
    applyStimulus(r2, 1'b1); checkOutput("gate_filt_r1");
    applyStimulus(r2, 1'b1); checkOutput("gate_flush_r2");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(rand_row(i % 2), 1'b1);
      checkOutput("random_stream");
    end

    $display("[TB] asynchronous reset mid-stream");
    doReset("midstream_reset");
    applyStimulus(rand_row(0), 1'b1);
    checkOutput("post_reset_load");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
